// File: rtl/stack_call_unit.sv
// stack_call_unit: call/return sequencer in front of the hardware stack.
// Expands CALL/RET/INT/RETI requests into single-cycle PUSH/POP commands and
// returns popped PC/flags with a one-cycle done pulse.
// Optional depth guard: define STACK_GUARD_EN to reject over/underflowing
// requests with an o_fault pulse instead of touching the stack.

package stack_pkg;
  typedef enum logic [1:0] {
    COM_NOP  = 2'b00,
    COM_PUSH = 2'b01,
    COM_POP  = 2'b10
  } command_t;
endpackage

module stack_call_unit
  import stack_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              i_Clk,
  input  logic              i_Reset_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [1:0]        i_req_op,
  input  logic [DATA_W-1:0] i_ret_addr,
  input  logic [DATA_W-1:0] i_flags,
  output logic              o_done,
  output logic [DATA_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_flags,
  output logic              o_flags_valid,
  output command_t          o_stk_command,
  output logic [DATA_W-1:0] o_stk_data,
  input  logic [DATA_W-1:0] i_stk_data,
  output logic              o_fault
);

  localparam logic [1:0] OpCall = 2'b00;
  localparam logic [1:0] OpRet  = 2'b01;
  localparam logic [1:0] OpInt  = 2'b10;
  localparam logic [1:0] OpReti = 2'b11;

  // RETI needs two words on the stack, so anything smaller is meaningless.
  if (DEPTH < 2) begin : g_bad_depth
    $error("stack_call_unit: DEPTH must be at least 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StPush1,
    StPush2,
    StPop1,
    StCap1,
    StPop2,
    StCap2,
    StDone
  } state_t;

  state_t            state_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] flags_q;
  logic              reject;

`ifdef STACK_GUARD_EN
  localparam int unsigned DepthW = $clog2(DEPTH + 1);

  logic [DepthW-1:0] depth_q;

  // Shadow depth tracks the commands actually issued to the stack.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      depth_q <= '0;
    end else if (o_stk_command == COM_PUSH) begin
      depth_q <= depth_q + 1'b1;
    end else if (o_stk_command == COM_POP) begin
      depth_q <= depth_q - 1'b1;
    end
  end

  // Reject any request that would overflow or underflow the stack.
  always_comb begin
    reject = 1'b0;
    unique case (i_req_op)
      OpCall:  reject = (32'(depth_q) + 32'd1) > DEPTH;
      OpInt:   reject = (32'(depth_q) + 32'd2) > DEPTH;
      OpRet:   reject = 32'(depth_q) < 32'd1;
      default: reject = 32'(depth_q) < 32'd2;
    endcase
  end
`else
  assign reject = 1'b0;
`endif

  // Sequencer: all outputs are registered and set on entry to the next state.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q       <= StIdle;
      op_q          <= OpCall;
      addr_q        <= '0;
      flags_q       <= '0;
      o_req_ready   <= 1'b1;
      o_done        <= 1'b0;
      o_flags_valid <= 1'b0;
      o_fault       <= 1'b0;
      o_stk_command <= COM_NOP;
      o_stk_data    <= '0;
      o_pc          <= '0;
      o_flags       <= '0;
    end else begin
      o_done        <= 1'b0;
      o_flags_valid <= 1'b0;
      o_fault       <= 1'b0;
      o_stk_command <= COM_NOP;
      unique case (state_q)
        StIdle: begin
          if (i_req_valid) begin
            op_q        <= i_req_op;
            addr_q      <= i_ret_addr;
            flags_q     <= i_flags;
            o_req_ready <= 1'b0;
            if (reject) begin
              state_q <= StDone;
              o_done  <= 1'b1;
              o_fault <= 1'b1;
            end else if (i_req_op == OpCall || i_req_op == OpInt) begin
              state_q       <= StPush1;
              o_stk_command <= COM_PUSH;
              o_stk_data    <= i_ret_addr;
            end else begin
              state_q       <= StPop1;
              o_stk_command <= COM_POP;
            end
          end
        end
        StPush1: begin
          if (op_q == OpInt) begin
            state_q       <= StPush2;
            o_stk_command <= COM_PUSH;
            o_stk_data    <= flags_q;
          end else begin
            state_q <= StDone;
            o_done  <= 1'b1;
          end
        end
        StPush2: begin
          state_q <= StDone;
          o_done  <= 1'b1;
        end
        StPop1: begin
          state_q <= StCap1;
        end
        StCap1: begin
          // Flags were pushed last by INT, so RETI sees them first.
          if (op_q == OpReti) begin
            o_flags       <= i_stk_data;
            state_q       <= StPop2;
            o_stk_command <= COM_POP;
          end else begin
            o_pc    <= i_stk_data;
            state_q <= StDone;
            o_done  <= 1'b1;
          end
        end
        StPop2: begin
          state_q <= StCap2;
        end
        StCap2: begin
          o_pc          <= i_stk_data;
          state_q       <= StDone;
          o_done        <= 1'b1;
          o_flags_valid <= 1'b1;
        end
        StDone: begin
          state_q     <= StIdle;
          o_req_ready <= 1'b1;
        end
        default: begin
          state_q     <= StIdle;
          o_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
